// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: owns the PC, drives the instruction port and
// buffers returned words in a small in-order queue ahead of decode.
module risc_toy_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [29:0] REDIRECT_ADDR,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTR,
  output logic [29:0] ID_PC,
  output logic [29:0] ID_PC_NEXT
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [29:0]     pc_reg, pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   head_reg, head_next;
  logic [PW-1:0]   tail_reg, tail_next;
  logic            inflight_reg, inflight_next;
  logic [29:0]     inflight_pc_reg, inflight_pc_next;
  logic [31:0]     id_instr_reg, id_instr_next;
  logic [29:0]     id_pc_reg, id_pc_next;

  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;
  logic [PW-1:0]   head_after_pop;
  logic [CW-1:0]   remaining;
  logic [61:0]     entry_data [FQ_DEPTH];

  assign ID_VALID   = (count_reg != '0);
  assign pop        = ID_VALID & ~STALL;
  assign push       = inflight_reg & (state_reg != S_FLUSH) & ~REDIRECT;
  // Words still owed to the queue after this cycle's pop; issuing only below
  // the depth guarantees every returning word finds a free slot.
  assign occupancy  = {1'b0, count_reg} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);

  assign IADDR      = pc_reg;
  assign ID_INSTR   = id_instr_reg;
  assign ID_PC      = id_pc_reg;
  assign ID_PC_NEXT = id_pc_reg + 30'd1;

  // FSM: state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   state_next = REDIRECT ? S_FLUSH : S_RUN;
      S_FLUSH: state_next = REDIRECT ? S_FLUSH : S_RUN;
      default: state_next = S_BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    IREQ = 1'b0;
    if ((state_reg == S_RUN) && !REDIRECT && (occupancy < DEPTH_W)) begin
      IREQ = 1'b1;
    end
  end

  // Queue storage, one register per entry; written at the tail on push.
  for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
    logic [61:0] data_reg;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        data_reg <= '0;
      end else if (push && (tail_reg == PW'(gi))) begin
        data_reg <= {INSTR, inflight_pc_reg};
      end
    end
    assign entry_data[gi] = data_reg;
  end

  assign head_after_pop = head_reg + PW'(pop);
  assign remaining      = count_reg - CW'(pop);

  always_comb begin
    pc_next          = pc_reg;
    count_next       = count_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;
    inflight_next    = IREQ;
    inflight_pc_next = inflight_pc_reg;
    id_instr_next    = id_instr_reg;
    id_pc_next       = id_pc_reg;
    if (REDIRECT) begin
      pc_next    = REDIRECT_ADDR;
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end else begin
      if (IREQ) begin
        pc_next          = pc_reg + 30'd1;
        inflight_pc_next = pc_reg;
      end
      head_next  = head_after_pop;
      count_next = remaining + CW'(push);
      if (push) begin
        tail_next = tail_reg + PW'(1);
      end
      // ID registers track the head the queue will have after this edge;
      // an empty queue leaves them holding the last instruction.
      if (remaining != '0) begin
        {id_instr_next, id_pc_next} = entry_data[head_after_pop];
      end else if (push) begin
        id_instr_next = INSTR;
        id_pc_next    = inflight_pc_reg;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_reg          <= RESET_PC;
      count_reg       <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      id_instr_reg    <= '0;
      id_pc_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      count_reg       <= count_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      id_instr_reg    <= id_instr_next;
      id_pc_reg       <= id_pc_next;
    end
  end

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && (count_reg == CW'(FQ_DEPTH))));

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Bench for risc_toy_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_risc_toy_fetch;
  localparam logic [29:0] RPC = 30'h10;
  localparam int D = 2;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [29:0] REDIRECT_ADDR = '0;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [29:0] ID_PC;
  logic [29:0] ID_PC_NEXT;

  int n_checks = 0;
  int n_pass = 0;

  risc_toy_fetch #(.RESET_PC(RPC), .FQ_DEPTH(D)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
    .ID_VALID(ID_VALID), .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .ID_PC_NEXT(ID_PC_NEXT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5AC3C3;
  endfunction

  // Instruction memory: answers the cycle after a request, junk otherwise.
  logic        mem_req = 1'b0;
  logic [29:0] mem_addr = '0;
  always @(posedge CLK) begin
    mem_req  <= IREQ;
    mem_addr <= IADDR;
  end
  assign INSTR = mem_req ? mem_word(mem_addr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference model: instruction queue plus fetch bookkeeping.
  logic [61:0] m_q[$];
  logic [29:0] m_pc = RPC;
  logic [29:0] m_infl_pc = '0;
  logic [29:0] m_last_pc = '0;
  logic [31:0] m_last_instr = '0;
  bit          m_boot = 1'b1;
  bit          m_flush = 1'b0;
  bit          m_infl = 1'b0;

  function automatic bit m_ireq();
    int occ;
    occ = m_q.size() + int'(m_infl) - ((m_q.size() > 0 && !STALL) ? 1 : 0);
    return !m_boot && !m_flush && !REDIRECT && (occ < D);
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    bit pop_now, issue_now;
    if (!RSTN) begin
      m_q.delete();
      m_pc = RPC; m_infl_pc = '0; m_last_pc = '0; m_last_instr = '0;
      m_boot = 1'b1; m_flush = 1'b0; m_infl = 1'b0;
    end else begin
      pop_now   = (m_q.size() > 0) && !STALL;
      issue_now = m_ireq();
      if (REDIRECT) begin
        m_q.delete();
        m_infl  = 1'b0;
        m_pc    = REDIRECT_ADDR;
        m_flush = !m_boot;
        m_boot  = 1'b0;
      end else begin
        if (pop_now) void'(m_q.pop_front());
        if (m_infl && !m_flush) m_q.push_back({mem_word(m_infl_pc), m_infl_pc});
        m_infl = issue_now;
        if (issue_now) begin
          m_infl_pc = m_pc;
          m_pc = m_pc + 30'd1;
        end
        m_boot = 1'b0;
        m_flush = 1'b0;
      end
      if (m_q.size() > 0) {m_last_instr, m_last_pc} = m_q[0];
    end
  end

  // Per-cycle compare plus an in-order pop monitor.
  logic [29:0] exp_pop = RPC;
  logic [29:0] m_next_pc;
  bit watch_40 = 1'b0;
  bit saw_40 = 1'b0;
  always @(negedge CLK) begin
    m_next_pc = m_last_pc + 30'd1;
    chk("ireq", IREQ, m_ireq());
    chk("iaddr", IADDR, m_pc);
    chk("id_valid", ID_VALID, m_q.size() > 0);
    chk("id_instr", ID_INSTR, m_last_instr);
    chk("id_pc", ID_PC, m_last_pc);
    chk("id_pc_next", ID_PC_NEXT, m_next_pc);
    if (!RSTN) exp_pop = RPC;
    else if (REDIRECT) exp_pop = REDIRECT_ADDR;
    else if (ID_VALID && !STALL) begin
      chk("pop_order", ID_PC, exp_pop);
      exp_pop = exp_pop + 30'd1;
    end
    if (watch_40 && IREQ && IADDR == 30'h40) saw_40 = 1'b1;
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    bit found;
    repeat (3) step();
    chk("rst_ireq", IREQ, 0);
    chk("rst_iaddr", IADDR, 30'h10);
    chk("rst_valid", ID_VALID, 0);
    chk("rst_instr", ID_INSTR, 0);
    chk("rst_pc", ID_PC, 0);

    // Boot bubble, then one fetch per cycle.
    RSTN = 1'b1;
    chk("boot_ireq", IREQ, 0);
    step(); chk("first_ireq", IREQ, 1); chk("first_iaddr", IADDR, 30'h10);
    step(); chk("second_iaddr", IADDR, 30'h11); chk("pre_valid", ID_VALID, 0);
    step();
    chk("first_valid", ID_VALID, 1);
    chk("first_pc", ID_PC, 30'h10);
    chk("first_pc_next", ID_PC_NEXT, 30'h11);
    chk("first_instr", ID_INSTR, 32'h5A5AC382);
    repeat (4) step();

    // Five-cycle stall mid-stream.
    STALL = 1'b1;
    repeat (2) step();
    chk("stall_ireq_low", IREQ, 0);
    chk("stall_valid", ID_VALID, 1);
    repeat (3) step();
    STALL = 1'b0;
    repeat (6) step();

    // Redirect with the queue at full occupancy and a word in flight.
    STALL = 1'b1; REDIRECT = 1'b1; REDIRECT_ADDR = 30'h200;
    step();
    REDIRECT = 1'b0; STALL = 1'b0;
    chk("flush_valid0", ID_VALID, 0);
    step(); chk("flush_valid1", ID_VALID, 0);
    step(); chk("flush_valid2", ID_VALID, 0);
    step(); chk("redir_valid", ID_VALID, 1); chk("redir_pc", ID_PC, 30'h200);
    repeat (3) step();

    // Back-to-back redirects: only the second target is fetched.
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h40;
    step();
    REDIRECT_ADDR = 30'h80;
    step();
    REDIRECT = 1'b0; watch_40 = 1'b1;
    repeat (3) step();
    chk("b2b_valid", ID_VALID, 1);
    chk("b2b_pc", ID_PC, 30'h80);
    repeat (4) step();
    chk("no_0x40_fetch", saw_40, 0);

    // PC wrap at the top of the address space.
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h3FFFFFFE;
    step();
    REDIRECT = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (IREQ && IADDR == 30'h3FFFFFFF) found = 1'b1;
      else step();
    end
    chk("wrap_fetch_seen", found, 1);
    step(); chk("wrap_iaddr", IADDR, 30'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (ID_VALID && ID_PC == 30'h3FFFFFFF) found = 1'b1;
      else step();
    end
    chk("wrap_id_seen", found, 1);
    chk("wrap_pc_next", ID_PC_NEXT, 30'h0);

    // Asynchronous reset with a stalled, full queue.
    STALL = 1'b1;
    repeat (4) step();
    chk("full_before_rst", ID_VALID, 1);
    RSTN = 1'b0;
    #1;
    chk("arst_ireq", IREQ, 0);
    chk("arst_valid", ID_VALID, 0);
    chk("arst_pc", ID_PC, 0);
    chk("arst_instr", ID_INSTR, 0);
    chk("arst_iaddr", IADDR, 30'h10);
    repeat (2) step();
    STALL = 1'b0; RSTN = 1'b1;
    step(); chk("restart_ireq", IREQ, 1); chk("restart_iaddr", IADDR, 30'h10);
    step(); step();
    chk("restart_valid", ID_VALID, 1);
    chk("restart_pc", ID_PC, 30'h10);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
